vga_fb_scanout: RTL and testbench
=================================

# vga_fb_scanout

Parametrised VGA scan-out engine: generates programmable horizontal/vertical timing and reads pixels from an internal framebuffer with optional integer pixel replication. A synchronous write port lets a producer (CPU, keyboard renderer) update the image while scanning. Sits between the board top and the VGA pins, replacing the fixed timing controller plus read-only picture memory.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- SCALE_LOG2, 0, each framebuffer pixel covers 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels
- FB_HW, 10, framebuffer column-index width; FB_VW, 9, row-index width
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable
- wr_en  in  1  framebuffer write strobe
- wr_addr  in  FB_HW+FB_VW  write address {row, col}
- wr_data  in  24  RGB888 write data
- pattern_sel  in  1  colour-bar select (only with VGA_FB_TEST_PATTERN_EN)
- hsync, vsync  out  1  active-low syncs
- valid  out  1  active-video flag (drives BLANK_N)
- vga_r, vga_g, vga_b  out  8 each  pixel colour, 0 when !valid
- frame_start  out  1  one-cycle pulse on first pixel of each frame

## Operation
- Reset: h_cnt=v_cnt=0, pipeline cleared; hsync=1, vsync=1, valid=0, RGB=0, frame_start=0.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; order per line: active, front porch, sync, back porch. Same for vertical.
- h_cnt counts 0..H_TOTAL-1 then wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- hsync low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync analogous on v_cnt.
- valid when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Read address = {v_cnt>>SCALE_LOG2, h_cnt>>SCALE_LOG2}, truncated to FB_VW/FB_HW bits; out-of-range reads during blanking are don't-care but RGB forced to 0.
- en low: counters held at 0; after pipeline drains outputs idle at reset values. en falling mid-frame: counters return to 0 next cycle, no partial-frame resume. en rising: scan starts at (0,0).
- Framebuffer depth 2^(FB_HW+FB_VW) × 24 bits, simple dual-port, synchronous read. Write occurs regardless of en.
- Same-address read and write in one cycle: read returns old data; new data visible next read.

## Timing
- Stage 0: counters; stage 1: RAM read plus delayed sync/valid; stage 2: registered outputs.
- All outputs delayed exactly 2 clk from counter state; syncs, valid and RGB stay mutually aligned.
- frame_start high 2 clk after counters reach (0,0) with en high.
- Write latency: data written at edge N readable by a read issued at edge N+1.
- rst overrides en and wr_en; a write on the reset cycle is dropped.

## Configuration
- VGA_FB_TEST_PATTERN_EN defined: pattern_sel port exists; when high, stage-2 RGB = 8 equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) by h_cnt/(H_ACTIVE/8), RAM ignored, timing unchanged.
- Undefined: no pattern_sel port, RGB always from framebuffer.

## Structure
- Package vga_fb_pkg: default 640×480 timing constants, rgb888 struct typedef, colour-bar constant array.
- Sub-module vga_fb_ram: parametrised simple dual-port sync-read RAM, read-old-on-collision.

## Test plan
- Small timing (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V 4/1/1/1): hsync low for h_cnt 10–11, period 14 clk; vsync low lines 5, frame 98 clk.
- Reset mid-line: outputs hsync=1, vsync=1, valid=0, RGB=0 on next cycle; scan restarts at (0,0).
- Write 0xFF0000 at {0,3}, SCALE_LOG2=0: pixel 3 of line 0 shows R=FF exactly 2 clk after h_cnt=3.
- SCALE_LOG2=1, write 0x00FF00 at {1,1}: screen pixels (2..3, lines 2..3) green, neighbours unchanged.
- Write and read same address in the scan cycle: old colour displayed this frame, new next frame.
- With VGA_FB_TEST_PATTERN_EN, pattern_sel=1, H_ACTIVE=8: pixels 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared definitions for the VGA framebuffer scan-out engine.
//   - Default 640x480 @ 60 Hz timing constants (pixels / lines).
//   - rgb888_t: packed RGB888 pixel.
//   - BAR_COLOURS: eight colour-bar values used by the optional test pattern,
//     index 0 is the leftmost bar.
package vga_fb_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Listed from index 7 down to index 0: black, blue, red, magenta,
  // green, cyan, yellow, white.
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/vga_fb_ram.sv
// vga_fb_ram: simple dual-port RAM with synchronous read.
//   On a same-address read/write in one cycle the read returns the old word;
//   the new word is visible to the next read.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  AW  write address
//   wr_data  in  DW  write data
//   rd_addr  in  AW  read address (read every cycle)
//   rd_data  out DW  registered read data
module vga_fb_ram
  import vga_fb_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; the consumer
  // masks the read data until the scan pipeline holds a visible pixel.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    // Non-blocking read samples the pre-write contents: read-old on collision.
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: programmable VGA timing generator with framebuffer scan-out.
//   Stage 0: h/v counters. Stage 1: RAM read plus delayed sync/valid/first.
//   Stage 2: registered outputs. All outputs lag the counters by 2 clk.
//   Optional feature: define VGA_FB_TEST_PATTERN_EN to add the pattern_sel
//   input, which replaces RAM data with eight vertical colour bars.
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   en           in   scan enable (low holds counters at 0, outputs idle)
//   wr_en        in   framebuffer write strobe (independent of en)
//   wr_addr      in   FB_VW+FB_HW write address {row, col}
//   wr_data      in   24  RGB888 write data
//   pattern_sel  in   colour-bar select (VGA_FB_TEST_PATTERN_EN only)
//   hsync/vsync  out  active-low syncs
//   valid        out  active-video flag
//   vga_r/g/b    out  8 each, zero outside active video
//   frame_start  out  one-cycle pulse on the first pixel of each frame
module vga_fb_scanout
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SCALE_LOG2 = 0,
  parameter int FB_HW      = 10,
  parameter int FB_VW      = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_en,
  input  logic [FB_HW+FB_VW-1:0] wr_addr,
  input  logic [23:0]            wr_data,
`ifdef VGA_FB_TEST_PATTERN_EN
  input  logic                   pattern_sel,
`endif
  output logic                   hsync,
  output logic                   vsync,
  output logic                   valid,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so the sync-end constants never wrap.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = FB_HW + FB_VW;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [AW-1:0] rd_addr;

  // Stage 1
  logic hsync1_q, hsync1_d;
  logic vsync1_q, vsync1_d;
  logic valid1_q, valid1_d;
  logic first1_q, first1_d;
  logic [23:0] ram_rd_data;

  // Stage 2
  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  logic    valid_q, valid_d;
  logic    frame_start_q, frame_start_d;
  rgb888_t rgb_q, rgb_d;

`ifdef VGA_FB_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  logic [2:0] bar1_q, bar1_d;
`endif

  // --------------------------------------------------------------------------
  // Stage 0: counters. Dropping en returns to (0,0) immediately so a
  // re-enabled scan always begins a fresh frame.
  // --------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // Scaled coordinates, truncated (or zero-extended) to the framebuffer size.
  assign rd_addr = {FB_VW'(v_cnt_q >> SCALE_LOG2), FB_HW'(h_cnt_q >> SCALE_LOG2)};

  // --------------------------------------------------------------------------
  // Stage 1: timing decode, qualified by en so the idle (0,0) counter state
  // is never mistaken for the first visible pixel.
  // --------------------------------------------------------------------------
  always_comb begin
    valid1_d = en && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hsync1_d = !(en && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vsync1_d = !(en && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    first1_d = en && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

`ifdef VGA_FB_TEST_PATTERN_EN
  // Only meaningful while valid; out-of-range quotients are masked later.
  assign bar1_d = 3'(h_cnt_q / HW'(BAR_W));
`endif

  // --------------------------------------------------------------------------
  // Stage 2: output registers; colour forced to zero outside active video.
  // --------------------------------------------------------------------------
  always_comb begin
    hsync_d       = hsync1_q;
    vsync_d       = vsync1_q;
    valid_d       = valid1_q;
    frame_start_d = first1_q;
    rgb_d         = '0;
    if (valid1_q) begin
      rgb_d = ram_rd_data;
`ifdef VGA_FB_TEST_PATTERN_EN
      if (pattern_sel) begin
        rgb_d = BAR_COLOURS[bar1_q];
      end
`endif
    end
  end

  // NOTE: state flops use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync1_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      valid1_q      <= 1'b0;
      first1_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
`ifdef VGA_FB_TEST_PATTERN_EN
      bar1_q        <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync1_q      <= hsync1_d;
      vsync1_q      <= vsync1_d;
      valid1_q      <= valid1_d;
      first1_q      <= first1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
`ifdef VGA_FB_TEST_PATTERN_EN
      bar1_q        <= bar1_d;
`endif
    end
  end

  // A write presented during reset is discarded.
  vga_fb_ram #(
    .AW (AW),
    .DW (24)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en && !rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench for vga_fb_scanout on a 14x7 raster
// (H 8/2/2/2, V 4/1/1/1), with one instance at SCALE_LOG2=0 (inst 0) and one
// at SCALE_LOG2=1 (inst 1) sharing all inputs. The framebuffer (8x4) is
// preloaded with 0x40|addr in blue so every pixel has a distinct colour.
// Screen position n = v*14 + h of a scan started with base cycle B appears
// on the outputs at cycle B + n.
module tb_vga_fb_scanout;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int FBH = 3, FBV = 2;

  logic        clk = 1'b0;
  logic        rst, en, wr_en;
  logic [4:0]  wr_addr;
  logic [23:0] wr_data;
`ifdef VGA_FB_TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  logic       hs0, vs0, vl0, fs0, hs1, vs1, vl1, fs1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int          cyc;
    logic        inst;
    logic [27:0] v;      // {hsync, vsync, valid, frame_start, rgb}
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_LOG2(0), .FB_HW(FBH), .FB_VW(FBV)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef VGA_FB_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .hsync(hs0), .vsync(vs0), .valid(vl0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0)
  );

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_LOG2(1), .FB_HW(FBH), .FB_VW(FBV)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef VGA_FB_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .hsync(hs1), .vsync(vs1), .valid(vl1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got hs=%b vs=%b valid=%b fs=%b rgb=%06h, expected hs=%b vs=%b valid=%b fs=%b rgb=%06h",
               nm, cyc, act[27], act[26], act[25], act[24], act[23:0],
               exp[27], exp[26], exp[25], exp[24], exp[23:0]);
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares it.
  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [27:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", nm, e.cyc, cyc);
      end else begin
        act = e.inst ? {hs1, vs1, vl1, fs1, r1, g1, b1} : {hs0, vs0, vl0, fs0, r0, g0, b0};
        check(nm, act, e.v);
      end
    end
  end

  task automatic push(input int c, input bit inst, input string nm, input logic hs,
                      input logic vs, input logic vl, input logic fs, input logic [23:0] rgb);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.v    = {hs, vs, vl, fs, rgb};
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic px(input int c, input bit inst, input string nm, input logic fs, input logic [23:0] rgb);
    push(c, inst, nm, 1'b1, 1'b1, 1'b1, fs, rgb);
  endtask

  task automatic blk(input int c, input bit inst, input string nm, input logic hs, input logic vs);
    push(c, inst, nm, hs, vs, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  int base, base2, base3;

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef VGA_FB_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    repeat (3) step();
    blk(cyc, 0, "reset_state_i0", 1, 1);
    blk(cyc, 1, "reset_state_i1", 1, 1);

    // Preload: blue = 0x40 | addr, written while en is low.
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = {16'h0, 8'h40 | 8'(a)};
      step();
    end
    wr_en = 1'b0;
    step();
    blk(cyc, 0, "idle_en_low", 1, 1);

    // Write on a reset cycle must be dropped: {0,4} keeps 0x44.
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 24'hABCDEF;
    step();
    rst = 1'b0;
    wr_addr = 5'd3; wr_data = 24'hFF0000; step();   // {0,3} red
    wr_addr = 5'd9; wr_data = 24'h00FF00; step();   // {1,1} green
    wr_en = 1'b0;

    en = 1'b1;
    base = cyc + 2;
    px (base + 0,   0, "p00_i0_first",   1, 24'h000040);
    px (base + 0,   1, "p00_i1_first",   1, 24'h000040);
    px (base + 1,   0, "p10_i0",         0, 24'h000041);
    px (base + 1,   1, "p10_i1",         0, 24'h000040);
    px (base + 2,   0, "p20_i0",         0, 24'h000042);
    px (base + 2,   1, "p20_i1",         0, 24'h000041);
    px (base + 3,   0, "p30_i0_red",     0, 24'hFF0000);
    px (base + 3,   1, "p30_i1",         0, 24'h000041);
    px (base + 4,   0, "p40_i0_rstwr",   0, 24'h000044);
    px (base + 4,   1, "p40_i1",         0, 24'h000042);
    px (base + 5,   0, "p50_i0_f0",      0, 24'h000045);
    px (base + 6,   1, "p60_i1_red",     0, 24'hFF0000);
    px (base + 7,   0, "p70_i0",         0, 24'h000047);
    px (base + 7,   1, "p70_i1_red",     0, 24'hFF0000);
    blk(base + 8,   0, "h8_fporch",      1, 1);
    blk(base + 10,  0, "h10_sync_i0",    0, 1);
    blk(base + 10,  1, "h10_sync_i1",    0, 1);
    blk(base + 11,  0, "h11_sync",       0, 1);
    blk(base + 12,  0, "h12_bporch",     1, 1);
    px (base + 15,  0, "p11_i0_green",   0, 24'h00FF00);
    px (base + 15,  1, "p11_i1",         0, 24'h000040);
    px (base + 16,  1, "p21_i1",         0, 24'h000041);
    px (base + 29,  0, "p12_i0",         0, 24'h000051);
    px (base + 29,  1, "p12_i1",         0, 24'h000048);
    px (base + 30,  1, "p22_i1_green",   0, 24'h00FF00);
    px (base + 31,  1, "p32_i1_green",   0, 24'h00FF00);
    px (base + 32,  1, "p42_i1",         0, 24'h00004A);
    px (base + 44,  1, "p23_i1_green",   0, 24'h00FF00);
    px (base + 45,  0, "p33_i0",         0, 24'h00005B);
    px (base + 45,  1, "p33_i1_green",   0, 24'h00FF00);
    blk(base + 56,  0, "v4_fporch_i0",   1, 1);
    blk(base + 56,  1, "v4_fporch_i1",   1, 1);
    blk(base + 58,  1, "p24_i1_blank",   1, 1);
    blk(base + 70,  0, "v5_vsync",       1, 0);
    blk(base + 80,  0, "v5_h10_both",    0, 0);
    blk(base + 84,  0, "v6_bporch",      1, 1);
    blk(base + 97,  0, "last_of_frame",  1, 1);
    px (base + 98,  0, "frame1_start_i0", 1, 24'h000040);
    px (base + 98,  1, "frame1_start_i1", 1, 24'h000040);
    px (base + 103, 0, "collide_old",    0, 24'h000045);
    px (base + 196, 0, "frame2_start",   1, 24'h000040);
    px (base + 201, 0, "collide_new",    0, 24'h123456);

    // Write {0,5} on the very edge that reads it for frame 1 (n=103).
    wait_cyc(base + 101);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 24'h123456;
    step();
    wr_en = 1'b0;

    // Reset mid-line, where hsync would otherwise be low (n=220, h=10).
    wait_cyc(base + 219);
    rst = 1'b1;
    step();
    rst = 1'b0;
    blk(cyc, 0, "midline_reset_i0", 1, 1);
    blk(cyc, 1, "midline_reset_i1", 1, 1);
    base2 = cyc + 2;
    px (base2 + 0,  0, "restart_i0",     1, 24'h000040);
    px (base2 + 0,  1, "restart_i1",     1, 24'h000040);
    px (base2 + 3,  0, "restart_red",    0, 24'hFF0000);
    blk(base2 + 10, 0, "restart_hsync",  0, 1);
    px (base2 + 21, 0, "en_fall_drain",  0, 24'h00004F);
    blk(base2 + 24, 0, "en_fall_idle",   1, 1);
    blk(base2 + 25, 0, "en_fall_idle2",  1, 1);

    wait_cyc(base2 + 20);
    en = 1'b0;

    wait_cyc(base2 + 30);
    en = 1'b1;
    base3 = cyc + 2;
    px (base3 + 0, 0, "en_rise_i0",      1, 24'h000040);
    px (base3 + 0, 1, "en_rise_i1",      1, 24'h000040);
    px (base3 + 1, 0, "en_rise_p10",     0, 24'h000041);
`ifdef VGA_FB_TEST_PATTERN_EN
    px (base3 + 98,  0, "bar0", 1, 24'hFFFFFF);
    px (base3 + 99,  0, "bar1", 0, 24'hFFFF00);
    px (base3 + 100, 0, "bar2", 0, 24'h00FFFF);
    px (base3 + 101, 0, "bar3", 0, 24'h00FF00);
    px (base3 + 102, 0, "bar4", 0, 24'hFF00FF);
    px (base3 + 103, 0, "bar5", 0, 24'hFF0000);
    px (base3 + 103, 1, "bar5_i1", 0, 24'hFF0000);
    px (base3 + 104, 0, "bar6", 0, 24'h0000FF);
    px (base3 + 105, 0, "bar7", 0, 24'h000000);
    blk(base3 + 108, 0, "bar_hsync", 0, 1);
    wait_cyc(base3 + 90);
    pattern_sel = 1'b1;
`endif

    for (int i = 0; i < 400 && sb.size() > 0; i++) step();
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
